// File: rtl/mux16_arbiter.sv
// mux16_arbiter: round-robin arbiter and select sequencer for a shared 16:1 bit mux.
// Define ARB_PREEMPT_EN to bound ownership to MAX_HOLD cycles while others are waiting.
module mux16_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic [15:0] req_i,
   input  logic [15:0] data_in_i,
   output logic [15:0] gnt_o,
   output logic [3:0]  sel_o,
   output logic        busy_o,
   output logic        data_out_o,
   output logic        data_valid_o
);
   typedef enum logic {IDLE, OWN} state_t;
   state_t     state_q, state_d;
   logic [3:0] ptr_q, ptr_d, owner_q, owner_d, win;
   logic       data_out_q, data_valid_q, exit_own;
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("MAX_HOLD must be within 2..255");
   end
   // lowest rotated offset from ptr wins, so scan offsets from high to low
   always_comb begin
      win = ptr_q;
      for (int i = 15; i >= 0; i--)
         if (req_i[ptr_q + 4'(i)]) win = ptr_q + 4'(i);
   end
`ifdef ARB_PREEMPT_EN
   localparam logic [7:0] CNT_MAX = 8'(MAX_HOLD - 1);
   logic [7:0] cnt_q, cnt_d;
   assign cnt_d    = state_q == IDLE ? 8'd0 : cnt_q == CNT_MAX ? cnt_q : cnt_q + 8'd1;
   assign exit_own = !req_i[owner_q] || (cnt_q == CNT_MAX && (req_i & ~(16'h1 << owner_q)) != '0);
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
`else
   assign exit_own = !req_i[owner_q];
`endif
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      if (state_q == IDLE) begin
         if (req_i != '0) begin
            state_d = OWN;
            owner_d = win;
         end
      end else if (exit_own) begin
         state_d = IDLE;
         ptr_d   = owner_q + 4'd1;
      end
   end
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         owner_q      <= '0;
         data_out_q   <= 1'b0;
         data_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         data_out_q   <= data_in_i[owner_q];
         data_valid_q <= state_q == OWN;
      end
   end
   // select only moves on IDLE->OWN, so the grant is never live during a sel change
   assign gnt_o        = state_q == OWN ? 16'h1 << owner_q : '0;
   assign sel_o        = owner_q;
   assign busy_o       = state_q == OWN;
   assign data_out_o   = data_out_q;
   assign data_valid_o = data_valid_q;
endmodule

// File: tb/tb_mux16_arbiter.sv
// tb_mux16_arbiter: directed plan scenarios plus randomized traffic against a cycle-level
// behavioural model of the arbiter (works with or without ARB_PREEMPT_EN).
module tb_mux16_arbiter;
   localparam int MH = 4;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] req = '0, din = '0;
   logic [15:0] gnt;
   logic [3:0]  sel;
   logic        busy, dout, dvalid;
   int          checks = 0, failures = 0;
   bit          m_own;
   int          m_owner, m_ptr, m_held;
   logic        m_dout, m_dv;

   mux16_arbiter #(.MAX_HOLD(MH)) dut (
      .clk_i(clk), .reset_n_i(rst_n), .req_i(req), .data_in_i(din),
      .gnt_o(gnt), .sel_o(sel), .busy_o(busy), .data_out_o(dout), .data_valid_o(dvalid)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_own = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_dout = 0; m_dv = 0;
   endtask

   // advance the model by one clock using the inputs that the coming edge will sample
   task automatic model_step();
      logic [15:0] others;
      bit preempt;
      m_dout = din[m_owner];
      m_dv   = m_own;
      if (!m_own) begin
         for (int k = 0; k < 16; k++)
            if (!m_own && req[(m_ptr + k) % 16]) begin
               m_own = 1; m_owner = (m_ptr + k) % 16; m_held = 1;
            end
      end else begin
         others  = req & ~(16'h1 << m_owner);
         preempt = 0;
`ifdef ARB_PREEMPT_EN
         preempt = m_held >= MH && others != 0;
`endif
         if (!req[m_owner] || preempt) begin
            m_own = 0; m_ptr = (m_owner + 1) % 16;
         end else m_held++;
      end
   endtask

   task automatic compare_all();
      check("gnt", 32'(gnt), m_own ? 32'(16'h1 << m_owner) : 32'd0);
      check("sel", 32'(sel), 32'(m_owner));
      check("busy", 32'(busy), 32'(m_own));
      check("data_out", 32'(dout), 32'(m_dout));
      check("data_valid", 32'(dvalid), 32'(m_dv));
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   // asynchronous reset between edges; outputs must clear before the next edge
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_dvalid", 32'(dvalid), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] exp_g;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      // single request
      req = 16'h0020;
      step();
      check("single_gnt", 32'(gnt), 32'h0020);
      check("single_sel", 32'(sel), 32'd5);
      repeat (4) step();
      req = '0;
      step();
      check("single_release", 32'(gnt), 32'd0);
      check("single_sel_hold", 32'(sel), 32'd5);
      req = 16'h0021;
      step();
      check("ptr_after_5", 32'(gnt), 32'h0001);
      req = '0;
      step();
      // wrap-around 0 -> 15 -> 0
      do_reset();
      req = 16'h8001;
      step(); check("wrap_g0", 32'(gnt), 32'h0001);
      step(); step();
      req = 16'h8000;
      step(); check("wrap_idle0", 32'(gnt), 32'd0);
      req = 16'h8001;
      step(); check("wrap_g15", 32'(gnt), 32'h8000);
      step(); step();
      req = 16'h0001;
      step(); check("wrap_idle15", 32'(gnt), 32'd0);
      req = 16'h8001;
      step(); check("wrap_g0_again", 32'(gnt), 32'h0001);
      req = '0;
      step();
      // preemption between 3 and 7
      do_reset();
      req = 16'h0088;
      for (int i = 0; i < 14; i++) begin
         step();
`ifdef ARB_PREEMPT_EN
         exp_g = (i % 10) < 4 ? 16'h0008 : (i % 10) == 4 ? 16'h0000 : (i % 10) < 9 ? 16'h0080 : 16'h0000;
`else
         exp_g = 16'h0008;
`endif
         check("preempt_seq", 32'(gnt), 32'(exp_g));
      end
      // lone owner is never preempted
      do_reset();
      req = 16'h0004;
      for (int i = 0; i < 10; i++) begin
         step();
         check("lone_gnt", 32'(gnt), 32'h0004);
      end
      req = '0;
      step();
      // datapath: owner 9, its data toggles, others held at 1
      do_reset();
      din = 16'hFFFF;
      req = 16'h0200;
      for (int i = 0; i < 8; i++) begin
         din[9] = i[0];
         step();
      end
      req = '0;
      step(); step();
      check("dp_valid_off", 32'(dvalid), 32'd0);
      // reset in the middle of ownership by 12, then 0 wins first
      req = 16'h1000;
      step();
      check("mid_gnt12", 32'(gnt), 32'h1000);
      step();
      do_reset();
      req = 16'h1001;
      step();
      check("post_reset_gnt0", 32'(gnt), 32'h0001);
      // randomized traffic with occasional asynchronous resets
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
               0: req = 16'(1 << $urandom_range(0, 15));
               1: req = 16'($urandom) & 16'($urandom);
               default: req = 16'($urandom);
            endcase
         end
         din = 16'($urandom);
         if ($urandom_range(0, 299) == 0) do_reset();
         else step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mux16_arbiter.md
# mux16_arbiter

Round-robin arbiter and sequencer for a shared 16:1 single-bit selection path. Up to 16 requesters compete for the path. The block grants one requester at a time and drives the 4-bit select of the 16:1 mux. It also registers the selected bit with a valid flag for the consumer. The block sits between the requesting units and the mux16_1 datapath, and is the only driver of that mux's `sel`.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive OWN cycles before preemption; legal range 2..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  16  request vector; bit k is held high by requester k while it wants the path.
- `data_in`  in  16  mux data inputs; bit k belongs to requester k.
- `gnt`  out  16  one-hot grant, or all-zero.
- `sel`  out  4  index of the current owner; drives the mux select.
- `busy`  out  1  high while in OWN.
- `data_out`  out  1  registered `data_in[sel]`.
- `data_valid`  out  1  `data_out` holds owner data.

## Operation
- State machine with two states, IDLE and OWN. Registers:
  - `state`
  - `ptr[3:0]`, the round-robin start index
  - `owner[3:0]`
  - `cnt[7:0]`, the hold counter
- **IDLE**
  - `gnt` is 0 and `busy` is 0.
  - If `req` is not 0, the winner is the first set bit searching ptr, ptr+1, …, 15, 0, …, ptr−1 (mod 16).
  - Next state is OWN, with `owner` = winner and `cnt` = 0.
- **OWN**
  - `gnt` = 1 << `owner`, `sel` = `owner`, `busy` = 1.
  - `cnt` increments each cycle and saturates at MAX_HOLD−1.
- **Exit from OWN to IDLE**, checked each cycle in OWN:
  - `req[owner]` == 0, or
  - preemption (see Configuration): `cnt` == MAX_HOLD−1 and (`req` with the owner bit masked) is not 0.
- **On exit**
  - `ptr` = (`owner`+1) mod 16, so 15 wraps to 0.
  - `gnt` goes to 0 for at least one full cycle (IDLE). The mux select never changes while a grant is asserted, which avoids glitches.
- `sel` retains the last owner while in IDLE. It changes only on an IDLE→OWN transition.
- **Datapath**
  - Every cycle: `data_out` <= `data_in[sel]` and `data_valid` <= (state == OWN).
  - `data_out` is therefore the bit sampled during the previous cycle's grant.
- **Simultaneous events**
  - Requests arriving while in OWN are ignored until the next IDLE cycle.
  - If the owner drops `req` in the same cycle that preemption fires, exit happens once; `ptr` update is identical.
- The owner re-requesting in the IDLE cycle is legal. It wins only if no other bit is found earlier in the search order.
- **Reset** (asynchronous, including mid-OWN). Immediately:
  - state = IDLE
  - `ptr` = 0, `owner` = 0, `cnt` = 0
  - `gnt` = 0, `sel` = 0, `busy` = 0
  - `data_out` = 0, `data_valid` = 0
- On reset release, the first grant can appear on the second rising edge.

## Timing
- Request to grant: `req` sampled high at edge t while in IDLE gives `gnt` and `sel` valid after edge t. Latency is 1 cycle.
- Release: `req[owner]` sampled low at edge t gives `gnt` = 0 after edge t.
  - The earliest next grant is after edge t+1, so the minimum dead cycle is 1.
- Data: `data_out` and `data_valid` lag `sel` and `busy` by exactly 1 cycle.
- Maximum ownership under contention is MAX_HOLD cycles. Worst-case wait for any requester is 15×(MAX_HOLD+1) cycles.
- All outputs come from registers; there is no combinational input-to-output path.

## Configuration
- `ARB_PREEMPT_EN`
  - Defined: `cnt` and the preemption exit condition are compiled in, as described above.
  - Undefined: `cnt` is not built. The owner keeps the grant until it drops `req`, with no bound on hold time. `MAX_HOLD` is ignored.

## Test plan
- **Single request:** after reset, `req` = 0x0020 held for 5 cycles, then 0.
  - `gnt` = 0x0020 and `sel` = 5 one cycle after `req` rises.
  - `gnt` = 0 one cycle after `req` falls.
  - `ptr` = 6 afterwards.
- **Wrap-around:** `req` = 0x8001 from reset (`ptr` = 0), each requester drops `req` 3 cycles after its grant.
  - Grant order is 0, then 15, then 0.
  - Each grant is separated by one IDLE cycle with `gnt` = 0.
- **Preemption:** with `ARB_PREEMPT_EN` defined, MAX_HOLD = 4, and `req` = 0x0088 held constant.
  - Grants go to 3 for 4 cycles, IDLE for 1, 7 for 4 cycles, IDLE for 1, then 3 again.
  - Without the macro, 3 holds indefinitely.
- **Lone owner:** MAX_HOLD = 4, only `req[2]` high for 10 cycles.
  - No preemption occurs.
  - `gnt` = 0x0004 is continuous for 10 cycles.
- **Datapath:** owner 9, `data_in[9]` toggles every cycle and all other `data_in` bits are held at 1.
  - `data_out` follows `data_in[9]` with 1-cycle delay.
  - `data_valid` = 1 from the cycle after the grant until the cycle after release.
- **Reset mid-OWN:** assert `reset_n` = 0 asynchronously between edges while owner = 12.
  - All outputs are 0 before the next edge.
  - After release with `req` = 0x1001, owner 0 is granted first (`ptr` was reset to 0).
